// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RISC-V style datapath (R-type, ld, sd, beq).
// Generates datapath strobes and mux selects and counts retired instructions.
//
//   state  | meaning
//   FETCH  | read instruction, PC += 4 on mem_ready
//   DECODE | register read, branch target into ALU
//   ADDR   | effective address for ld/sd
//   MEM_RD | load access, wait for mem_ready
//   MEM_WR | store access, wait for mem_ready
//   WB_LD  | write load data to register file
//   EXEC_R | R-type ALU operation
//   WB_R   | write ALU result to register file
//   BRANCH | compare, PC <= target when zero
//   HALT   | illegal opcode, left only by rst
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [3:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_ADDR   = 4'd2,
        S_MEM_RD = 4'd3,
        S_MEM_WR = 4'd4,
        S_WB_LD  = 4'd5,
        S_EXEC_R = 4'd6,
        S_WB_R   = 4'd7,
        S_BRANCH = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] SRC_B_RS2 = 2'b00;
    localparam logic [1:0] SRC_B_4   = 2'b01;
    localparam logic [1:0] SRC_B_IMM = 2'b10;
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    state_t           state_q;
    state_t           state_d;
    logic             retire;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are gated by rst so every strobe is low while reset is held,
    // even though FETCH itself would otherwise assert mem_read.
    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_ADD;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRC_B_4;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_b = SRC_B_IMM;
                    case (opcode)
                        OP_R:         state_d = S_EXEC_R;
                        OP_LD, OP_SD: state_d = S_ADDR;
                        OP_BEQ:       state_d = S_BRANCH;
                        default:      state_d = S_HALT;
                    endcase
                end
                S_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRC_B_IMM;
                    if (opcode == OP_LD) begin
                        state_d = S_MEM_RD;
                    end else if (opcode == OP_SD) begin
                        state_d = S_MEM_WR;
                    end else begin
                        state_d = S_HALT;
                    end
                end
                S_MEM_RD: begin
                    mem_read  = 1'b1;
                    alu_src_a = 1'b1;
                    if (mem_ready) begin
                        state_d = S_WB_LD;
                    end
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    alu_src_a = 1'b1;
                    if (mem_ready) begin
                        state_d = S_FETCH;
                    end
                end
                S_WB_LD: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    state_d    = S_FETCH;
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRC_B_RS2;
                    alu_op    = ALU_FUNCT;
                    state_d   = S_WB_R;
                end
                S_WB_R: begin
                    reg_write = 1'b1;
                    alu_op    = ALU_FUNCT;
                    state_d   = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRC_B_RS2;
                    alu_op    = ALU_SUB;
                    pc_src    = 1'b1;
                    pc_write  = zero;
                    state_d   = S_FETCH;
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_HALT;
                end
            endcase
        end
    end

    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_MEM_WR) || (state_q == S_WB_LD) ||
                     (state_q == S_WB_R)   || (state_q == S_BRANCH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (retire) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign state       = state_q;
    assign halted      = (state_q == S_HALT);
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: state traces, strobes, retire counter,
// halt, async reset and a random mem_ready run with mutual-exclusion checks.
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = OP_R;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_write, ir_write, reg_write, mem_read, mem_write;
    logic       mem_to_reg, pc_src, alu_src_a, halted;
    logic [1:0] alu_src_b, alu_op;
    logic [3:0] state;
    logic [3:0] instr_count;

    int checks   = 0;
    int failures = 0;
    logic [7:0] rw_m, mtr_m, pcw_m;
    logic [6:0] ops [4];

    multicycle_ctrl #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .state(state), .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    assert property (@(posedge clk) disable iff (rst) !(mem_read && mem_write));
    assert property (@(posedge clk) disable iff (rst) !(reg_write && mem_write));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // seq holds one state code per nibble, first cycle in the low nibble
    task automatic trace(input string tag, input logic [31:0] seq, input int n,
                         input logic [7:0] rdy, output logic [7:0] rw,
                         output logic [7:0] mtr, output logic [7:0] pcw);
        rw = '0; mtr = '0; pcw = '0;
        for (int i = 0; i < n; i++) begin
            mem_ready = rdy[i];
            #1;
            chk(tag, {28'd0, state}, {28'd0, seq[4*i +: 4]});
            rw[i]  = reg_write;
            mtr[i] = mem_to_reg;
            pcw[i] = pc_write;
            step();
        end
    endtask

    initial begin
        ops[0] = OP_R; ops[1] = OP_LD; ops[2] = OP_SD; ops[3] = OP_BEQ;
        repeat (3) step();
        chk("rst_state", state, 0);
        chk("rst_cnt", instr_count, 0);
        chk("rst_halted", halted, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_ir_write", ir_write, 0);
        chk("rst_pc_write", pc_write, 0);
        rst = 1'b0;
        #1;
        chk("fetch_mem_read", mem_read, 1);
        chk("fetch_ir_write", ir_write, 1);
        chk("fetch_src_b", alu_src_b, 2'b01);

        trace("rtype_state", 32'h7610, 4, 8'h0F, rw_m, mtr_m, pcw_m);
        chk("rtype_rw", rw_m, 8'h08);
        chk("rtype_end", state, 0);
        chk("rtype_cnt", instr_count, 1);

        opcode = OP_LD;
        trace("ld_state", 32'h5333210, 7, 8'h21, rw_m, mtr_m, pcw_m);
        chk("ld_mtr", mtr_m, 8'h40);
        chk("ld_rw", rw_m, 8'h40);
        chk("ld_end", state, 0);
        chk("ld_cnt", instr_count, 2);

        opcode = OP_SD;
        trace("sd_state", 32'h44210, 5, 8'h17, rw_m, mtr_m, pcw_m);
        chk("sd_rw", rw_m, 8'h00);
        chk("sd_cnt", instr_count, 3);

        opcode = OP_BEQ;
        zero = 1'b1;
        trace("beq1_state", 32'h810, 3, 8'h07, rw_m, mtr_m, pcw_m);
        chk("beq1_pcw", pcw_m, 8'h05);
        chk("beq1_cnt", instr_count, 4);
        zero = 1'b0;
        trace("beq0_state", 32'h810, 3, 8'h07, rw_m, mtr_m, pcw_m);
        chk("beq0_pcw", pcw_m, 8'h01);
        chk("beq0_cnt", instr_count, 5);

        opcode = OP_R;
        trace("fwait_state", 32'h76100, 5, 8'h1E, rw_m, mtr_m, pcw_m);
        chk("fwait_rw", rw_m, 8'h10);
        chk("fwait_pcw", pcw_m, 8'h02);
        chk("fwait_cnt", instr_count, 6);

        opcode = OP_BAD;
        trace("bad_state", 32'h10, 2, 8'h03, rw_m, mtr_m, pcw_m);
        chk("halt_state", state, 9);
        chk("halt_flag", halted, 1);
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom_range(1));
            opcode = ops[i % 4];
            step();
            chk("halt_stay", state, 9);
        end
        chk("halt_mem_read", mem_read, 0);
        chk("halt_cnt", instr_count, 6);
        rst = 1'b1;
        #1;
        chk("halt_rst_state", state, 0);
        chk("halt_rst_cnt", instr_count, 0);
        chk("halt_rst_flag", halted, 0);
        step();
        rst = 1'b0;

        opcode = OP_R;
        for (int k = 1; k <= 16; k++) begin
            trace("wrap_state", 32'h7610, 4, 8'h0F, rw_m, mtr_m, pcw_m);
            if (k == 15) chk("wrap_cnt15", instr_count, 15);
            if (k == 16) chk("wrap_cnt0", instr_count, 0);
        end

        opcode = OP_SD;
        trace("sdrst_state", 32'h210, 3, 8'h07, rw_m, mtr_m, pcw_m);
        mem_ready = 1'b0;
        #1;
        chk("sdrst_in_wr", state, 4);
        chk("sdrst_mw", mem_write, 1);
        step();
        chk("sdrst_wait", state, 4);
        rst = 1'b1;
        #1;
        chk("sdrst_mw_drop", mem_write, 0);
        chk("sdrst_state", state, 0);
        chk("sdrst_cnt", instr_count, 0);
        step();
        rst = 1'b0;
        #1;
        chk("sdrst_after", state, 0);
        opcode = OP_R;
        trace("post_state", 32'h7610, 4, 8'h0F, rw_m, mtr_m, pcw_m);
        chk("post_cnt", instr_count, 1);

        for (int i = 0; i < 400; i++) begin
            if (state == 4'd0) opcode = ops[$urandom_range(3)];
            mem_ready = 1'($urandom_range(1));
            zero = 1'($urandom_range(1));
            #1;
            chk("rand_rd_wr", {31'd0, mem_read & mem_write}, 0);
            chk("rand_rw_wr", {31'd0, reg_write & mem_write}, 0);
            step();
        end
        chk("rand_halted", halted, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
